// File: rtl/accumulate_stage.sv
// Accumulator behind a valid/ready handshake: accept -> result valid after one edge, held until out_ready; one op per 2 cycles.
// Optional feature macro SATURATE_EN: a carrying add loads all ones instead of the wrapped sum.

module ripple_carry_adder #(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               carryin,
  output logic [NUMBITS-1:0] sum,
  output logic               carryout
);
  always_comb begin
    logic c;
    c = carryin;
    sum = '0;
    for (int i = 0; i < NUMBITS; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carryout = c;
  end
endmodule

module accumulate_stage #(
  parameter int NUMBITS = 8,
  parameter int CNTBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] out_sum,
  output logic               out_carry,
  output logic               carry_sticky,
  output logic [CNTBITS-1:0] op_count
);
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUMBITS-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               sticky_q, sticky_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;

  logic [NUMBITS-1:0] add_sum;
  logic               add_co;
  logic               accept;

  ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
    .a        (acc_q),
    .b        (in_data),
    .carryin  (1'b0),
    .sum      (add_sum),
    .carryout (add_co)
  );

  assign in_ready     = (state_q == IDLE) && !clear;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_q == RESP);
  assign out_sum      = acc_q;
  assign out_carry    = carry_q;
  assign carry_sticky = sticky_q;
  assign op_count     = cnt_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clear) begin
      // clear wins over both accept and a pending result
      state_d  = IDLE;
      acc_d    = '0;
      carry_d  = 1'b0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef SATURATE_EN
            acc_d = add_co ? {NUMBITS{1'b1}} : add_sum;
`else
            acc_d = add_sum;
`endif
            carry_d  = add_co;
            sticky_d = sticky_q | add_co;
            cnt_d    = cnt_q + CNTBITS'(1);
            state_d  = RESP;
          end
        end
        RESP: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
